// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared clock/baud constants and receiver state type
package definitions_pkg;
  localparam int CLOCK_RATE         = 50_000_000;
  localparam int BAUD_RATE          = 115_200;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider, restartable so ticks align to a frame
module uart_baud_tick #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_wrap && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clear || w_wrap)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8N1 UART receiver with valid/ready output hold
module uart_receiver #(
  parameter int OVERSAMPLE = definitions_pkg::OVERSAMPLE_DEFAULT,
  parameter int CLOCK_RATE = definitions_pkg::CLOCK_RATE,
  parameter int BAUD_RATE  = definitions_pkg::BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enabled,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun
);
  import definitions_pkg::*;

  localparam int TICK_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  logic          r_sync1, r_sync2, r_sync3;
  rx_state_t     r_state, w_state_next;
  logic [SW-1:0] r_sample_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift, r_data;
  logic          r_valid, r_load, r_frame_error, r_overrun;
  logic          w_tick, w_fall, w_clear, w_mid, w_bit_end;

  assign w_fall    = r_sync3 && !r_sync2;
  assign w_clear   = (r_state == IDLE) && enabled && w_fall;
  assign w_mid     = w_tick && (r_sample_cnt == MID);
  assign w_bit_end = w_tick && (r_sample_cnt == LAST);

  assign data        = r_data;
  assign valid       = r_valid;
  assign busy        = (r_state != IDLE);
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_clear) w_state_next = START;
      START: if (w_mid) w_state_next = r_sync2 ? IDLE : DATA;
      DATA:  if (w_bit_end && r_bit_cnt == 3'd7) w_state_next = STOP;
      STOP:  if (w_bit_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (!enabled)
      w_state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_sync3       <= 1'b1;
      r_sample_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_load        <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_sync1       <= in;
      r_sync2       <= r_sync1;
      r_sync3       <= r_sync2;
      r_load        <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;

      if (!enabled || r_state == IDLE) begin
        r_sample_cnt <= '0;
        r_bit_cnt    <= '0;
      end else if (r_state == START) begin
        if (w_mid)
          r_sample_cnt <= '0;
        else if (w_tick)
          r_sample_cnt <= r_sample_cnt + SW'(1);
      end else if (w_bit_end) begin
        r_sample_cnt <= '0;
        if (r_state == DATA) begin
          r_shift   <= {r_sync2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
          r_load        <= r_sync2;
          r_frame_error <= !r_sync2;
        end
      end else if (w_tick) begin
        r_sample_cnt <= r_sample_cnt + SW'(1);
      end

      // A byte landing in the same clk as an accept replaces the accepted one, so no overrun.
      if (r_load) begin
        r_data    <= r_shift;
        r_valid   <= 1'b1;
        r_overrun <= r_valid && !ready;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule
